// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the peripheral bus (address bit 31).
// Optional ACCESS timeout: define PERIPH_ARB_TIMEOUT_EN.
module periph_bus_arbiter #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_rw,
   input  logic [DATA_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_rw,
   input  logic [DATA_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [DATA_W-1:0] m_rdata,
   output logic              bus_ce,
   output logic              bus_rw,
   output logic [DATA_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ready,
   output logic [1:0]        grant
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_ERR} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_last_m1;
   logic [1:0]        r_grant;
   logic              r_bus_rw;
   logic [DATA_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              w_any_req;
   logic              w_pick_m1;
   logic              w_addr_ok;
   logic              w_timeout;

   assign w_any_req = m0_req | m1_req;
   // Contention goes to whichever master did not own the previous grant.
   assign w_pick_m1 = m1_req & (~m0_req | ~r_last_m1);
   assign w_addr_ok = r_bus_addr[DATA_W-1];

`ifdef PERIPH_ARB_TIMEOUT_EN
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [7:0] r_cnt;

   assign w_timeout = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == S_ACCESS && w_addr_ok && !bus_ready && !w_timeout) begin
         r_cnt <= r_cnt + 8'd1;
      end else begin
         r_cnt <= '0;
      end
   end
`else
   logic w_unused_timeout;

   assign w_timeout        = 1'b0;
   assign w_unused_timeout = (TIMEOUT == 0);
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_next = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // A non-peripheral address is rejected here, after latching, without raising bus_ce.
            if (!w_addr_ok) begin
               w_next = S_ERR;
            end else if (bus_ready) begin
               w_next = S_RESP;
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end
         S_RESP:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_m1   <= 1'b1;
         r_grant     <= 2'b00;
         r_bus_rw    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_rdata     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_grant     <= w_pick_m1 ? 2'b10 : 2'b01;
                  r_last_m1   <= w_pick_m1;
                  r_bus_rw    <= w_pick_m1 ? m1_rw    : m0_rw;
                  r_bus_addr  <= w_pick_m1 ? m1_addr  : m0_addr;
                  r_bus_wdata <= w_pick_m1 ? m1_wdata : m0_wdata;
               end
            end
            S_ACCESS: begin
               if (w_addr_ok && bus_ready) begin
                  r_rdata <= r_bus_rw ? '0 : bus_rdata;
               end
            end
            S_RESP, S_ERR: begin
               r_grant <= 2'b00;
               r_rdata <= '0;
            end
            default: begin
               r_grant <= 2'b00;
            end
         endcase
      end
   end

   assign bus_ce    = (r_state == S_ACCESS) & w_addr_ok;
   assign bus_rw    = r_bus_rw;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign m_rdata   = r_rdata;
   assign grant     = r_grant;
   assign m0_ack    = (r_state == S_RESP) & r_grant[0];
   assign m1_ack    = (r_state == S_RESP) & r_grant[1];
   assign m0_err    = (r_state == S_ERR)  & r_grant[0];
   assign m1_err    = (r_state == S_ERR)  & r_grant[1];

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomized self-checking bench for periph_bus_arbiter against a transaction-level model.
module tb_periph_bus_arbiter;

   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_req, m0_rw, m1_req, m1_rw;
   logic [DW-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic          m0_ack, m0_err, m1_ack, m1_err;
   logic [DW-1:0] m_rdata, bus_addr, bus_wdata, bus_rdata;
   logic          bus_ce, bus_rw, bus_ready;
   logic [1:0]    grant;

   int n_vec  = 0;
   int n_fail = 0;
   int last_win;   // model: master that owned the most recent grant

   periph_bus_arbiter #(.DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m0_req),
      .m0_rw     (m0_rw),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_ack    (m0_ack),
      .m0_err    (m0_err),
      .m1_req    (m1_req),
      .m1_rw     (m1_rw),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_ack    (m1_ack),
      .m1_err    (m1_err),
      .m_rdata   (m_rdata),
      .bus_ce    (bus_ce),
      .bus_rw    (bus_rw),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ready (bus_ready),
      .grant     (grant)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] resp_bits();
      return {m1_ack, m1_err, m0_ack, m0_err};
   endfunction

   // Called at a negedge with the DUT idle; master fields are already set by the caller.
   task automatic run_txn(input bit q0, input bit q1, input int wait_n,
                          input logic [DW-1:0] rd, input bit scramble);
      int            win;
      logic          w_rw;
      logic [DW-1:0] w_addr, w_wd;
      logic [3:0]    exp_ack, exp_err;
      m0_req    = q0;
      m1_req    = q1;
      bus_ready = 1'b0;
      if (!q0 && !q1) begin
         @(negedge clk);
         check("idle_grant", grant, 2'b00);
         check("idle_ce", bus_ce, 1'b0);
         check("idle_resp", resp_bits(), 4'b0000);
         return;
      end
      win      = (q0 && q1) ? 1 - last_win : (q1 ? 1 : 0);
      last_win = win;
      w_rw     = win ? m1_rw    : m0_rw;
      w_addr   = win ? m1_addr  : m0_addr;
      w_wd     = win ? m1_wdata : m0_wdata;
      exp_ack  = win ? 4'b1000 : 4'b0010;
      exp_err  = win ? 4'b0100 : 4'b0001;
      @(negedge clk);
      check("grant", grant, win ? 2'b10 : 2'b01);
      check("bus_rw", bus_rw, w_rw);
      check("bus_addr", bus_addr, w_addr);
      check("bus_wdata", bus_wdata, w_wd);
      if (scramble) begin
         m0_req  = 1'($urandom);
         m1_req  = 1'($urandom);
         m0_addr = $urandom;
         m1_addr = $urandom;
      end
      if (w_addr[DW-1]) begin
         for (int k = 0; k < wait_n; k++) begin
            check("wait_ce", bus_ce, 1'b1);
            check("wait_resp", resp_bits(), 4'b0000);
            check("wait_addr", bus_addr, w_addr);
            @(negedge clk);
         end
         check("acc_ce", bus_ce, 1'b1);
         bus_ready = 1'b1;
         bus_rdata = rd;
         @(negedge clk);
         bus_ready = 1'b0;
         bus_rdata = $urandom;
         check("ack", resp_bits(), exp_ack);
         check("rdata", m_rdata, w_rw ? '0 : rd);
         check("resp_ce", bus_ce, 1'b0);
         check("resp_grant", grant, win ? 2'b10 : 2'b01);
      end else begin
         check("bad_ce", bus_ce, 1'b0);
         check("bad_resp", resp_bits(), 4'b0000);
         @(negedge clk);
         check("err", resp_bits(), exp_err);
         check("err_rdata", m_rdata, '0);
         check("err_ce", bus_ce, 1'b0);
      end
      @(negedge clk);
      check("done_grant", grant, 2'b00);
      check("done_resp", resp_bits(), 4'b0000);
      check("done_ce", bus_ce, 1'b0);
   endtask

`ifdef PERIPH_ARB_TIMEOUT_EN
   task automatic run_timeout();
      m0_req    = 1'b1;
      m1_req    = 1'b0;
      m0_rw     = 1'b0;
      m0_addr   = 32'h8000_0500;
      bus_ready = 1'b0;
      last_win  = 0;
      @(negedge clk);
      m0_req = 1'b0;
      for (int k = 0; k < TIMEOUT; k++) begin
         check("to_ce", bus_ce, 1'b1);
         check("to_resp", resp_bits(), 4'b0000);
         @(negedge clk);
      end
      check("to_err", resp_bits(), 4'b0001);
      check("to_ce_off", bus_ce, 1'b0);
      check("to_rdata", m_rdata, '0);
      @(negedge clk);
      check("to_idle", grant, 2'b00);
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      m0_req    = 1'b0;  m1_req   = 1'b0;
      m0_rw     = 1'b0;  m1_rw    = 1'b0;
      m0_addr   = '0;    m1_addr  = '0;
      m0_wdata  = '0;    m1_wdata = '0;
      bus_rdata = '0;    bus_ready = 1'b0;
      last_win  = 1;
      @(negedge clk);
      @(negedge clk);
      check("rst_outs", {grant, resp_bits(), bus_ce, bus_rw}, '0);
      check("rst_bus", {bus_addr, bus_wdata}, '0);
      check("rst_rdata", m_rdata, '0);
      rst_n = 1'b1;

      // Zero-wait m0 read.
      m0_rw = 1'b0; m0_addr = 32'h8000_0110;
      run_txn(1'b1, 1'b0, 0, 32'hDEAD_BEEF, 1'b0);

      // Both masters hold write requests: alternating ownership.
      m0_rw = 1'b1; m0_addr = 32'h8000_0200; m0_wdata = 32'h0000_AAAA;
      m1_rw = 1'b1; m1_addr = 32'h8000_0300; m1_wdata = 32'h0000_BBBB;
      for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b1, 0, 32'h1234_5678, 1'b0);

      // m1 write outside the peripheral window.
      m1_rw = 1'b1; m1_addr = 32'h0000_0040; m1_wdata = 32'h5555_5555;
      run_txn(1'b0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0);

`ifdef PERIPH_ARB_TIMEOUT_EN
      run_timeout();
`else
      m0_rw = 1'b0; m0_addr = 32'h8000_0500;
      run_txn(1'b1, 1'b0, 20, 32'hCAFE_0001, 1'b0);
`endif

      // Reset during ACCESS of an m0 read.
      m0_rw = 1'b0; m0_addr = 32'h8000_0044;
      m0_req = 1'b1; m1_req = 1'b0;
      @(negedge clk);
      check("pre_rst_ce", bus_ce, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs", {grant, resp_bits(), bus_ce, bus_rw}, '0);
      check("rst_mid_bus", {bus_addr, bus_wdata, m_rdata}, '0);
      @(negedge clk);
      check("rst_hold_resp", resp_bits(), 4'b0000);
      rst_n    = 1'b1;
      last_win = 1;
      m1_rw = 1'b0; m1_addr = 32'h8000_0ABC;
      run_txn(1'b1, 1'b1, 1, 32'h0BAD_F00D, 1'b0);

      // Write with ready: ack with zero read data.
      m0_rw = 1'b1; m0_addr = 32'h8000_0020; m0_wdata = 32'h7777_0000;
      run_txn(1'b1, 1'b0, 0, 32'h9999_9999, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         m0_rw    = 1'($urandom);
         m1_rw    = 1'($urandom);
         m0_addr  = $urandom;
         m1_addr  = $urandom;
         m0_addr[DW-1] = ($urandom_range(0, 7) != 0);
         m1_addr[DW-1] = ($urandom_range(0, 7) != 0);
         m0_wdata = $urandom;
         m1_wdata = $urandom;
         run_txn(1'($urandom), 1'($urandom), int'($urandom_range(0, 5)), $urandom,
                 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
